// File: rtl/pc_branch_unit.sv
// ----------------------------------------------------------------------------
// pc_branch_unit
//   Program-counter and control-flow unit for the pipelined CPU. Owns the run
//   state (IDLE/EXEC/HALT), the fetch address and the squash window that
//   follows a taken branch. Branch conditions are resolved against cf/zf/nf.
//
//   Optional feature macro: RAS_ENABLE_EN
//     defined   : return-address stack (CALL via br_link, RET via br_type 111)
//     undefined : no stack storage, br_link ignored, RET never taken,
//                 ras_err tied low
//
// Parameters
//   PC_W        width of pc / fetch address / branch target
//   FLUSH_DEPTH cycles flush stays high after a taken branch (>=1)
//   RESET_PC    pc loaded on reset and on every start
//   RAS_DEPTH   return-address-stack entries (RAS_ENABLE_EN only)
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   enable       in   0 freezes all state; fetch_valid/flush forced low
//   start        in   run request, honoured in IDLE or HALT only
//   halt_req     in   HALT decoded in id stage
//   stall        in   pipeline hazard stall, holds pc
//   br_valid     in   branch resolved this cycle
//   br_type      in   000 JUMP 001 BZ 010 BNZ 011 BN 100 BNN 101 BC 110 BNC 111 RET
//   br_link      in   CALL: push return address when taken
//   br_target    in   branch destination
//   flag_cf/zf/nf in  condition flags
//   pc           out  current fetch address
//   fetch_valid  out  fetch at pc is live
//   flush        out  squash if/id stages
//   state        out  00 IDLE, 01 EXEC, 10 HALT
//   ras_err      out  sticky RAS underflow/overflow
// ----------------------------------------------------------------------------
module pc_branch_unit #(
    parameter int PC_W        = 8,
    parameter int FLUSH_DEPTH = 3,
    parameter int RESET_PC    = 0,
    parameter int RAS_DEPTH   = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            start,
    input  logic            halt_req,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [2:0]      br_type,
    input  logic            br_link,
    input  logic [PC_W-1:0] br_target,
    input  logic            flag_cf,
    input  logic            flag_zf,
    input  logic            flag_nf,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            flush,
    output logic [1:0]      state,
    output logic            ras_err
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    localparam logic [2:0] BT_JUMP = 3'b000;
    localparam logic [2:0] BT_BZ   = 3'b001;
    localparam logic [2:0] BT_BNZ  = 3'b010;
    localparam logic [2:0] BT_BN   = 3'b011;
    localparam logic [2:0] BT_BNN  = 3'b100;
    localparam logic [2:0] BT_BC   = 3'b101;
    localparam logic [2:0] BT_BNC  = 3'b110;
    localparam logic [2:0] BT_RET  = 3'b111;

    localparam int              FC_W   = $clog2(FLUSH_DEPTH + 1);
    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    logic [1:0]      state_q;
    logic [PC_W-1:0] pc_q;
    logic            fv_q;
    logic [FC_W-1:0] flush_cnt;

    logic            flushing;
    logic [PC_W-1:0] pc_inc;
    logic [FC_W-1:0] flush_dec;
    logic            cond_ok;
    logic            taken;
    logic [PC_W-1:0] taken_target;
    logic            start_go;

    assign flushing  = (flush_cnt != '0);
    assign pc_inc    = pc_q + PC_W'(1);
    assign flush_dec = flushing ? flush_cnt - FC_W'(1) : '0;
    assign start_go  = enable && (state_q != ST_EXEC) && start;

    always_comb begin
        cond_ok = 1'b0;
        case (br_type)
            BT_JUMP: cond_ok = 1'b1;
            BT_BZ:   cond_ok = flag_zf;
            BT_BNZ:  cond_ok = !flag_zf;
            BT_BN:   cond_ok = flag_nf;
            BT_BNN:  cond_ok = !flag_nf;
            BT_BC:   cond_ok = flag_cf;
            BT_BNC:  cond_ok = !flag_cf;
`ifdef RAS_ENABLE_EN
            BT_RET:  cond_ok = 1'b1;
`else
            BT_RET:  cond_ok = 1'b0;
`endif
            default: cond_ok = 1'b0;
        endcase
    end

    // Branches arriving inside the squash window belong to squashed
    // instructions, so they are never taken.
    assign taken = br_valid && !flushing && cond_ok;

`ifdef RAS_ENABLE_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_err_q;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic             ras_empty;
    logic             ras_full;
    logic [PC_W-1:0]  pop_value;
    logic             is_ret;
    logic             exec_take;
    logic             do_push;
    logic             do_pop;

    // Circular buffer: ras_ptr is the next free slot; when full, a push
    // lands on the oldest entry, which is exactly the one to discard.
    assign ptr_inc   = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PTR_W'(1);
    assign ptr_dec   = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - PTR_W'(1);
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign pop_value = ras_empty ? PC_RST : ras_mem[ptr_dec];
    assign is_ret    = (br_type == BT_RET);
    assign exec_take = enable && (state_q == ST_EXEC) && !halt_req && taken;
    // RET only pops; br_link on a RET is not a push.
    assign do_push   = exec_take && br_link && !is_ret;
    assign do_pop    = exec_take && is_ret;

    assign taken_target = is_ret ? pop_value : br_target;
    assign ras_err      = ras_err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ras_ptr   <= '0;
            ras_cnt   <= '0;
            ras_err_q <= 1'b0;
        end else if (start_go) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (do_push) begin
            ras_ptr <= ptr_inc;
            if (ras_full) begin
                ras_err_q <= 1'b1;
            end else begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (do_pop) begin
            if (ras_empty) begin
                ras_err_q <= 1'b1;
            end else begin
                ras_ptr <= ptr_dec;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            ras_mem[ras_ptr] <= pc_inc;
        end
    end
`else
    logic                           unused_link;
    logic [$clog2(RAS_DEPTH+1)-1:0] unused_ras_depth;

    assign unused_link      = br_link;
    assign unused_ras_depth = '0;
    assign taken_target     = br_target;
    assign ras_err          = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_RST;
            fv_q      <= 1'b0;
            flush_cnt <= '0;
        end else if (enable) begin
            case (state_q)
                ST_EXEC: begin
                    if (halt_req) begin
                        state_q   <= ST_HALT;
                        fv_q      <= 1'b0;
                        flush_cnt <= '0;
                    end else if (taken) begin
                        pc_q      <= taken_target;
                        fv_q      <= 1'b1;
                        flush_cnt <= FC_W'(FLUSH_DEPTH);
                    end else if (stall) begin
                        fv_q      <= 1'b0;
                        flush_cnt <= flush_dec;
                    end else begin
                        pc_q      <= pc_inc;
                        fv_q      <= 1'b1;
                        flush_cnt <= flush_dec;
                    end
                end
                default: begin
                    if (start) begin
                        state_q   <= ST_EXEC;
                        pc_q      <= PC_RST;
                        fv_q      <= 1'b1;
                        flush_cnt <= '0;
                    end else begin
                        fv_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign state       = state_q;
    assign fetch_valid = enable && fv_q;
    assign flush       = enable && flushing;

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

    localparam int PC_W        = 8;
    localparam int FLUSH_DEPTH = 3;
    localparam int RESET_PC    = 0;
    localparam int RAS_DEPTH   = 4;
    localparam int PC_MASK     = (1 << PC_W) - 1;

    logic            clock;
    logic            reset;
    logic            enable;
    logic            start;
    logic            halt_req;
    logic            stall;
    logic            br_valid;
    logic [2:0]      br_type;
    logic            br_link;
    logic [PC_W-1:0] br_target;
    logic            flag_cf;
    logic            flag_zf;
    logic            flag_nf;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic            flush;
    logic [1:0]      state;
    logic            ras_err;

    pc_branch_unit #(
        .PC_W(PC_W),
        .FLUSH_DEPTH(FLUSH_DEPTH),
        .RESET_PC(RESET_PC),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .start(start),
        .halt_req(halt_req),
        .stall(stall),
        .br_valid(br_valid),
        .br_type(br_type),
        .br_link(br_link),
        .br_target(br_target),
        .flag_cf(flag_cf),
        .flag_zf(flag_zf),
        .flag_nf(flag_nf),
        .pc(pc),
        .fetch_valid(fetch_valid),
        .flush(flush),
        .state(state),
        .ras_err(ras_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: run state as 0/1/2, pc as an integer, flush as cycles left,
    // return stack as a queue (back = most recent).
    int m_state;
    int m_pc;
    int m_fv;
    int m_flush_left;
    int m_err;
    int m_stack[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state      = 0;
        m_pc         = RESET_PC;
        m_fv         = 0;
        m_flush_left = 0;
        m_err        = 0;
        m_stack.delete();
    endtask

    function automatic bit cond_holds(input int t, input bit cf, input bit zf, input bit nf);
        case (t)
            0: return 1'b1;
            1: return zf;
            2: return !zf;
            3: return nf;
            4: return !nf;
            5: return cf;
            6: return !cf;
`ifdef RAS_ENABLE_EN
            7: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        int tgt;
        if (!enable) return;
        if (m_state != 1) begin
            if (start) begin
                m_state      = 1;
                m_pc         = RESET_PC;
                m_fv         = 1;
                m_flush_left = 0;
                m_stack.delete();
            end else begin
                m_fv = 0;
            end
            return;
        end
        if (halt_req) begin
            m_state      = 2;
            m_fv         = 0;
            m_flush_left = 0;
            return;
        end
        if (br_valid && m_flush_left == 0 &&
            cond_holds(int'(br_type), flag_cf, flag_zf, flag_nf)) begin
            tgt = int'(br_target);
`ifdef RAS_ENABLE_EN
            if (br_type == 3'd7) begin
                if (m_stack.size() == 0) begin
                    tgt   = RESET_PC;
                    m_err = 1;
                end else begin
                    tgt = m_stack.pop_back();
                end
            end else if (br_link) begin
                m_stack.push_back((m_pc + 1) & PC_MASK);
                if (m_stack.size() > RAS_DEPTH) begin
                    void'(m_stack.pop_front());
                    m_err = 1;
                end
            end
`endif
            m_pc         = tgt;
            m_fv         = 1;
            m_flush_left = FLUSH_DEPTH;
        end else begin
            if (m_flush_left > 0) m_flush_left--;
            if (stall) begin
                m_fv = 0;
            end else begin
                m_pc = (m_pc + 1) & PC_MASK;
                m_fv = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state));
        check("pc", 32'(pc), 32'(m_pc));
        check("fetch_valid", 32'(fetch_valid), 32'(enable && m_fv != 0));
        check("flush", 32'(flush), 32'(enable && m_flush_left > 0));
        check("ras_err", 32'(ras_err), 32'(m_err));
    endtask

    task automatic idle_inputs();
        enable    = 1'b1;
        start     = 1'b0;
        halt_req  = 1'b0;
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_type   = 3'd0;
        br_link   = 1'b0;
        br_target = '0;
        flag_cf   = 1'b0;
        flag_zf   = 1'b0;
        flag_nf   = 1'b0;
    endtask

    // Inputs are driven at the falling edge; one step = rising edge + model update,
    // then outputs are compared at the next falling edge.
    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic jump_to(input int tgt);
        br_valid  = 1'b1;
        br_type   = 3'd0;
        br_target = PC_W'(tgt);
        step();
        br_valid  = 1'b0;
    endtask

    initial begin
        int types[3];
        int exp_pc;
        int save_pc;

        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        compare_all();
        check("rst_pc", 32'(pc), 32'(RESET_PC));
        reset = 1'b0;

        // start, then sequential fetch
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_state", 32'(state), 32'd1);
        check("start_pc", 32'(pc), 32'h00);
        step();
        check("inc_pc", 32'(pc), 32'h01);

        // JUMP from 0x01 with a second branch inside the squash window
        jump_to(32'h21);
        check("jmp_pc0", 32'(pc), 32'h21);
        check("jmp_fl0", 32'(flush), 32'd1);
        br_valid  = 1'b1;
        br_target = 8'h55;
        step();
        check("jmp_pc1", 32'(pc), 32'h22);
        br_valid = 1'b0;
        step();
        check("jmp_pc2", 32'(pc), 32'h23);
        check("jmp_fl2", 32'(flush), 32'd1);
        step();
        check("jmp_pc3", 32'(pc), 32'h24);
        check("jmp_fl3", 32'(flush), 32'd0);

        // conditional branches: not-taken then taken for BZ, BC, BNN
        types = '{1, 5, 4};
        foreach (types[i]) begin
            for (int want = 0; want < 2; want++) begin
                flag_zf = 1'b0;
                flag_cf = 1'b0;
                flag_nf = 1'b0;
                case (types[i])
                    1: flag_zf = want[0];
                    5: flag_cf = want[0];
                    default: flag_nf = !want[0];
                endcase
                exp_pc    = want ? 32'h40 : ((m_pc + 1) & PC_MASK);
                br_valid  = 1'b1;
                br_type   = 3'(types[i]);
                br_target = 8'h40;
                step();
                br_valid = 1'b0;
                check("cond_pc", 32'(pc), 32'(exp_pc));
                check("cond_fl", 32'(flush), 32'(want));
                if (want != 0) begin
                    for (int k = 0; k < FLUSH_DEPTH; k++) step();
                    check("cond_fl_end", 32'(flush), 32'd0);
                end
            end
        end
        flag_zf = 1'b0;
        flag_cf = 1'b0;
        flag_nf = 1'b0;

        // wrap-around and stall
        jump_to(32'hFE);
        step();
        check("wrap_ff", 32'(pc), 32'hFF);
        step();
        check("wrap_00", 32'(pc), 32'h00);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall_pc", 32'(pc), 32'h00);
            check("stall_fv", 32'(fetch_valid), 32'd0);
        end
        stall = 1'b0;

        // enable low freezes everything despite active inputs
        save_pc   = m_pc;
        enable    = 1'b0;
        start     = 1'b1;
        br_valid  = 1'b1;
        br_target = 8'h77;
        for (int k = 0; k < 3; k++) begin
            step();
            check("frz_pc", 32'(pc), 32'(save_pc));
            check("frz_fv", 32'(fetch_valid), 32'd0);
        end
        idle_inputs();

        // halt at 0x10 (still inside a flush window), restart
        jump_to(32'h0E);
        step();
        step();
        check("pre_halt_pc", 32'(pc), 32'h10);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_state", 32'(state), 32'd2);
        check("halt_pc", 32'(pc), 32'h10);
        check("halt_fl", 32'(flush), 32'd0);
        step();
        check("halt_hold", 32'(pc), 32'h10);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_state", 32'(state), 32'd1);
        check("restart_pc", 32'(pc), 32'h00);

        // asynchronous reset in the middle of a flush window
        jump_to(32'h30);
        check("pre_rst_fl", 32'(flush), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_fl", 32'(flush), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        compare_all();
        @(negedge clock);
        reset = 1'b0;
        compare_all();
        start = 1'b1;
        step();
        start = 1'b0;

        // return-address stack
        for (int k = 0; k < 5; k++) step();
        check("call_pc", 32'(pc), 32'h05);
`ifdef RAS_ENABLE_EN
        br_link = 1'b1;
        jump_to(32'h40);
        br_link = 1'b0;
        check("call_tgt", 32'(pc), 32'h40);
        for (int k = 0; k < FLUSH_DEPTH; k++) step();
        br_valid = 1'b1;
        br_type  = 3'd7;
        step();
        br_valid = 1'b0;
        check("ret_pc", 32'(pc), 32'h06);
        check("ret_err", 32'(ras_err), 32'd0);
        for (int k = 0; k < FLUSH_DEPTH; k++) step();
        br_valid = 1'b1;
        br_type  = 3'd7;
        step();
        br_valid = 1'b0;
        check("ret_empty_pc", 32'(pc), 32'(RESET_PC));
        check("ret_empty_err", 32'(ras_err), 32'd1);
`else
        br_valid = 1'b1;
        br_type  = 3'd7;
        br_link  = 1'b1;
        step();
        idle_inputs();
        check("ret_off_pc", 32'(pc), 32'h06);
        check("ret_off_fl", 32'(flush), 32'd0);
        check("ret_off_err", 32'(ras_err), 32'd0);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 400 == 0) begin
                reset = 1'b1;
                #2;
                model_reset();
                compare_all();
                reset = 1'b0;
            end
            enable    = ($urandom % 10) != 0;
            start     = ($urandom % 20) == 0;
            halt_req  = ($urandom % 40) == 0;
            stall     = ($urandom % 6) == 0;
            br_valid  = ($urandom % 3) == 0;
            br_type   = 3'($urandom % 8);
            br_link   = 1'($urandom % 2);
            br_target = PC_W'($urandom);
            flag_cf   = 1'($urandom % 2);
            flag_zf   = 1'($urandom % 2);
            flag_nf   = 1'($urandom % 2);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
